// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared defaults and state encoding for the frame-buffer RAM responder
package fb_pkg;

  localparam int FB_ADDRESS_WIDTH = 6;
  localparam int FB_DATA_WIDTH    = 10;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } fb_state_t;

endpackage

// File: rtl/fb_ram_array.sv
// rtl/fb_ram_array.sv - single-write-port word array with registered, write-first read
// Ports:
//   clk, rst       clock; rst clears only the read register, never the array
//   we/waddr/wdata write port, written on the rising edge
//   re/raddr       read request; rdata is updated on the edge where re=1
//   rdata          registered read data (write-first on an address collision)
module fb_ram_array
  import fb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = FB_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = FB_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDRESS_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-edge write to the read address is forwarded so the reader sees the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/fb_ram_responder.sv
// rtl/fb_ram_responder.sv - CPU/loader shared RAM with power-up clear sweep
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   MAR, RAMWr, MDRIn        CPU address, write strobe, write data
//   MDROut                   CPU read data, one cycle after the request
//   cpu_hold                 high while the CPU must be kept in reset (CLEAR, LOAD)
//   ld_mode                  loader asks to own the memory (level)
//   ld_valid/ld_ready        loader request handshake; ld_we selects write or read
//   ld_addr, ld_wdata        loader address and write data
//   rd_valid, rd_data        loader read response, one cycle after the transfer
//   init_done                set once the clear sweep has finished
module fb_ram_responder
  import fb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = FB_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = FB_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] MAR,
  input  logic                     RAMWr,
  input  logic [DATA_WIDTH-1:0]    MDRIn,
  output logic [DATA_WIDTH-1:0]    MDROut,
  output logic                     cpu_hold,
  input  logic                     ld_mode,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic                     ld_we,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]    ld_wdata,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     init_done
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

  fb_state_t                state_q, state_n;
  logic [ADDRESS_WIDTH-1:0] clr_cnt;
  logic                     init_done_q;
  logic                     rd_valid_q;
  logic                     cpu_rd_q;
  logic [DATA_WIDTH-1:0]    mdr_hold;
  logic                     ld_xfer;

  logic                     arr_we, arr_re;
  logic [ADDRESS_WIDTH-1:0] arr_waddr, arr_raddr;
  logic [DATA_WIDTH-1:0]    arr_wdata, arr_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state plus the state-selected mux onto the single array port.
  always_comb begin
    state_n   = state_q;
    ld_xfer   = 1'b0;
    arr_we    = 1'b0;
    arr_waddr = clr_cnt;
    arr_wdata = '0;
    arr_re    = 1'b0;
    arr_raddr = MAR;
    case (state_q)
      CLEAR: begin
        arr_we = 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          state_n = ld_mode ? LOAD : RUN;
        end
      end
      RUN: begin
        arr_we    = RAMWr;
        arr_waddr = MAR;
        arr_wdata = MDRIn;
        arr_re    = 1'b1;
        if (ld_mode) begin
          state_n = LOAD;
        end
      end
      LOAD: begin
        ld_xfer   = ld_valid;
        arr_we    = ld_valid && ld_we;
        arr_waddr = ld_addr;
        arr_wdata = ld_wdata;
        arr_re    = ld_valid && !ld_we;
        arr_raddr = ld_addr;
        if (!ld_mode) begin
          state_n = RUN;
        end
      end
      default: state_n = CLEAR;
    endcase
    if (rst) begin
      arr_we  = 1'b0;
      ld_xfer = 1'b0;
    end
  end

  // cpu_rd_q marks that the array read register holds a CPU result; otherwise
  // MDROut replays the last value it showed so loader reads never disturb it.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt     <= '0;
      init_done_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      cpu_rd_q    <= 1'b0;
      mdr_hold    <= '0;
    end else begin
      if (state_q == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          init_done_q <= 1'b1;
        end
      end
      rd_valid_q <= ld_xfer && !ld_we;
      cpu_rd_q   <= (state_q == RUN);
      mdr_hold   <= MDROut;
    end
  end

  fb_ram_array #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .re   (arr_re),
    .raddr(arr_raddr),
    .rdata(arr_rdata)
  );

  assign MDROut    = cpu_rd_q ? arr_rdata : mdr_hold;
  assign rd_data   = arr_rdata;
  assign rd_valid  = rd_valid_q;
  assign init_done = init_done_q;
  assign cpu_hold  = (state_q != RUN);
  assign ld_ready  = (state_q == LOAD);

endmodule
